// File: rtl/chi_stage_pkg.sv
// chi_stage_pkg: Keccak geometry, chi cycle count and FSM encodings for chi_stage.
// CHI_ROW_PARALLEL_EN shortens the run to one row (5 cells) per cycle.
package chi_stage_pkg;
    localparam int NUM_ROW     = 5;
    localparam int NUM_COLUMN  = 5;
    localparam int NUM_PAGE    = 64;
    localparam int NUM_CELLS   = NUM_ROW * NUM_COLUMN * NUM_PAGE;
    localparam int LEN_ADDRESS = 11;
`ifdef CHI_ROW_PARALLEL_EN
    localparam int CHI_CYCLES  = NUM_COLUMN * NUM_PAGE;
`else
    localparam int CHI_CYCLES  = NUM_CELLS;
`endif

    typedef enum logic [1:0] {
        CHI_IDLE = 2'd0,
        CHI_RUN  = 2'd1,
        CHI_DONE = 2'd2
    } chi_state_e;

    function automatic logic [2:0] wrap5(input logic [2:0] v);
        return (v >= 3'd5) ? v - 3'd5 : v;
    endfunction
endpackage

// File: rtl/chi_stage_bit.sv
// chi_bit: single Keccak chi cell, y = a ^ (~b & c).
module chi_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);
    assign y = a ^ (~b & c);
endmodule

// File: rtl/chi_stage.sv
// chi_stage: Keccak chi step over the latched rho/pi output, one cell per cycle.
// CHI_ROW_PARALLEL_EN: drops the row counter and writes a whole 5-cell row per cycle.
module chi_stage
    import chi_stage_pkg::*;
#(
    parameter int LANE_WIDTH = NUM_PAGE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [25*LANE_WIDTH-1:0]    data_in,
    output logic                        busy,
    output logic                        done,
    output logic [25*LANE_WIDTH-1:0]    data_out
);
    localparam int CELLS = NUM_ROW * NUM_COLUMN * LANE_WIDTH;
    localparam int KW = (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(LANE_WIDTH - 1);

    chi_state_e state_q, state_d;
    logic [CELLS-1:0] latch_q, latch_d, out_q, out_d;
    logic [2:0] j_q, j_d;
    logic [KW-1:0] k_q, k_d;
    logic [LEN_ADDRESS-1:0] base;
    logic i_last, j_last, k_last;

    assign base = LEN_ADDRESS'(k_q) * LEN_ADDRESS'(NUM_ROW * NUM_COLUMN)
                + LEN_ADDRESS'(j_q) * LEN_ADDRESS'(NUM_ROW);
    assign j_last = (j_q == 3'(NUM_COLUMN - 1));
    assign k_last = (k_q == K_LAST);

`ifdef CHI_ROW_PARALLEL_EN
    logic [NUM_ROW-1:0] row_y;
    assign i_last = 1'b1;
    for (genvar x = 0; x < NUM_ROW; x++) begin : g_row
        chi_bit u_bit (
            .a(latch_q[base + LEN_ADDRESS'(x)]),
            .b(latch_q[base + LEN_ADDRESS'(wrap5(3'(x + 1)))]),
            .c(latch_q[base + LEN_ADDRESS'(wrap5(3'(x + 2)))]),
            .y(row_y[x])
        );
    end
`else
    logic [2:0] i_q, i_d;
    logic cell_y;
    assign i_last = (i_q == 3'(NUM_ROW - 1));
    chi_bit u_bit (
        .a(latch_q[base + LEN_ADDRESS'(i_q)]),
        .b(latch_q[base + LEN_ADDRESS'(wrap5(i_q + 3'd1))]),
        .c(latch_q[base + LEN_ADDRESS'(wrap5(i_q + 3'd2))]),
        .y(cell_y)
    );
`endif

    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        out_d   = out_q;
        j_d     = j_q;
        k_d     = k_q;
`ifndef CHI_ROW_PARALLEL_EN
        i_d     = i_q;
`endif
        if (state_q == CHI_RUN) begin
`ifdef CHI_ROW_PARALLEL_EN
            for (int x = 0; x < NUM_ROW; x++) out_d[base + LEN_ADDRESS'(x)] = row_y[x];
`else
            out_d[base + LEN_ADDRESS'(i_q)] = cell_y;
            i_d = i_last ? 3'd0 : i_q + 3'd1;
`endif
            if (i_last) j_d = j_last ? 3'd0 : j_q + 3'd1;
            if (i_last && j_last) k_d = k_last ? '0 : k_q + 1'b1;
            if (i_last && j_last && k_last) state_d = CHI_DONE;
        end else if (start) begin
            // DONE accepts start like IDLE, giving back-to-back runs without a bubble
            state_d = CHI_RUN;
            latch_d = data_in;
            j_d     = '0;
            k_d     = '0;
`ifndef CHI_ROW_PARALLEL_EN
            i_d     = '0;
`endif
        end else if (state_q == CHI_DONE) begin
            state_d = CHI_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CHI_IDLE;
            latch_q <= '0;
            out_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
`ifndef CHI_ROW_PARALLEL_EN
            i_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
            out_q   <= out_d;
            j_q     <= j_d;
            k_q     <= k_d;
`ifndef CHI_ROW_PARALLEL_EN
            i_q     <= i_d;
`endif
        end
    end

    assign busy     = (state_q == CHI_RUN);
    assign done     = (state_q == CHI_DONE);
    assign data_out = out_q;
endmodule

// File: tb/tb_chi_stage.sv
// tb_chi_stage: directed vectors for chi_stage with a done-driven scoreboard monitor.
module tb_chi_stage;
    import chi_stage_pkg::*;

    localparam int N      = NUM_CELLS;
    localparam int CYC    = CHI_CYCLES;
    localparam int RST_AT = CYC * 7 / 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [N-1:0] data_in = '0;
    logic busy, done;
    logic [N-1:0] data_out;

    chi_stage #(.LANE_WIDTH(NUM_PAGE)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .data_in(data_in),
        .busy(busy),
        .done(done),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] sb_d[$];
    int sb_c[$];
    logic [N-1:0] m_d;
    int m_c;

    function automatic int ones(input logic [N-1:0] v);
        int n = 0;
        for (int i = 0; i < N; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [N-1:0] mk(input int a, input int b, input int c);
        logic [N-1:0] v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    task automatic chk_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic chk_vec(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
        int first = -1;
        checks++;
        if (got !== want) begin
            errors++;
            for (int i = 0; i < N; i++) if (got[i] !== want[i]) begin first = i; break; end
            $display("FAIL %s first_diff_bit=%0d got_ones=%0d want_ones=%0d", name, first, ones(got), ones(want));
        end
    endtask

    always @(negedge clk) begin
        if (rst && done) begin
            if (sb_d.size() == 0) begin
                chk_int("unexpected_done", 1, 0);
            end else begin
                m_d = sb_d.pop_front();
                m_c = sb_c.pop_front();
                chk_vec("data_out", data_out, m_d);
                chk_int("done_latency_cycle", cyc, m_c);
                chk_int("busy_in_done", int'(busy), 0);
            end
        end
    end

    task automatic issue(input logic [N-1:0] d, input logic [N-1:0] e);
        data_in = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb_d.push_back(e);
        sb_c.push_back(cyc + CYC);
    endtask

    task automatic wait_done(input string name, output int when, output int gaps);
        int ok = 0;
        gaps = 0;
        when = -1;
        for (int n = 0; n < CYC + 20; n++) begin
            @(negedge clk);
            if (done) begin ok = 1; when = cyc; break; end
            if (!busy) gaps++;
        end
        chk_int(name, ok, 1);
    endtask

    int t_done, t_done2, gaps;

    initial begin
        repeat (3) @(negedge clk);
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_done", int'(done), 0);
        chk_vec("reset_data", data_out, '0);
        rst = 1'b1;

        @(negedge clk);
        issue('0, '0);
        wait_done("timeout_zero", t_done, gaps);
        chk_int("busy_gaps_zero", gaps, 0);

        @(negedge clk);
        issue('1, '1);
        wait_done("timeout_ones", t_done, gaps);

        @(negedge clk);
        issue(mk(1, -1, -1), mk(1, 4, -1));
        wait_done("timeout_bit1", t_done, gaps);

        // x=0,y=2,z=31 alone -> cells x=0 and x=3 of that row
        @(negedge clk);
        issue(mk(785, -1, -1), mk(785, 788, -1));
        data_in = '1;
        repeat (9) @(negedge clk);
        start = 1'b1;
        data_in = mk(3, 7, 11);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (CYC / 2 - 11) @(negedge clk);
        start = 1'b1;
        data_in = '1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("timeout_ignored_start", t_done, gaps);

        // back-to-back: start during the DONE cycle; top row y=4,z=63 with x=1,2 set
        issue(mk(1596, 1597, -1), mk(1596, 1597, 1599));
        wait_done("timeout_b2b", t_done2, gaps);
        chk_int("b2b_gap", t_done2 - t_done, CYC + 1);

        @(negedge clk);
        issue('1, '1);
        repeat (RST_AT) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk_vec("async_rst_data", data_out, '0);
        chk_int("async_rst_busy", int'(busy), 0);
        chk_int("async_rst_done", int'(done), 0);
        sb_d.delete();
        sb_c.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_int("post_rst_busy", int'(busy), 0);
        issue(mk(134, -1, -1), mk(132, 134, -1));
        wait_done("timeout_post_rst", t_done, gaps);
        chk_int("busy_gaps_post_rst", gaps, 0);

        repeat (3) @(negedge clk);
        chk_int("scoreboard_empty", sb_d.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
